// File: rtl/mouse_bus_peripheral_if.sv
// Mouse-side and processor-side signals of the mouse bus peripheral, minus the tristate data line.
// Pure wiring, no latency of its own.
// No backpressure: the transceiver pulses MOUSE_VALID and the processor acknowledges IRQ_RAISE with IRQ_ACKED.
//
// master : transceiver/processor side (drives mouse inputs, address, write strobe, ack)
// slave  : peripheral side (consumes the above, drives IRQ_RAISE)
// BUS_DATA stays a plain inout on the peripheral, so the shared line resolves as an ordinary net.
interface mouse_bus_peripheral_if;
    logic       MOUSE_VALID;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_X;
    logic [7:0] MOUSE_Y;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic [7:0] MOUSE_SCROLL;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       IRQ_RAISE;
    logic       IRQ_ACKED;

    modport master (
        output MOUSE_VALID, MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_DX, MOUSE_DY, MOUSE_SCROLL,
        output BUS_ADDR, BUS_WE, IRQ_ACKED,
        input  IRQ_RAISE
    );

    modport slave (
        input  MOUSE_VALID, MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_DX, MOUSE_DY, MOUSE_SCROLL,
        input  BUS_ADDR, BUS_WE, IRQ_ACKED,
        output IRQ_RAISE
    );
endinterface

// File: rtl/mouse_bus_peripheral.sv
// Memory-mapped slave that snapshots each completed mouse packet and raises a level interrupt until acked.
// Capture one cycle after MOUSE_VALID; read data on BUS_DATA one cycle after the address; IRQ_RAISE registered.
// No backpressure: every packet is captured (latest wins) and a capture over an unacked one sets OVERRUN.
//
// Ports:
//   CLK, RESET : system clock, asynchronous active-high reset
//   bus        : mouse inputs, BUS_ADDR/BUS_WE, IRQ_RAISE/IRQ_ACKED (slave modport)
//   BUS_DATA   : shared 8-bit data line, driven only in the cycle after a read hit
// Register window at BASE_ADDR: 0 STATUS, 1 X, 2 Y, 3 DX, 4 DY, 5 SCROLL, 6 EVCOUNT, 7 CTRL.
// CTRL: [0] IRQ_EN (R/W), [1] OVERRUN (write 1 clears), [2] PENDING (read-only), [7:3] zero.
module mouse_bus_peripheral #(
    parameter logic [7:0] BASE_ADDR    = 8'hA0,
    parameter logic       IRQ_EN_RESET = 1'b1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    mouse_bus_peripheral_if.slave         bus,
    inout  wire  [7:0]                    BUS_DATA
);

    logic       validD;
    logic [7:0] statusReg;
    logic [7:0] xReg;
    logic [7:0] yReg;
    logic [7:0] dxReg;
    logic [7:0] dyReg;
    logic [7:0] scrollReg;
    logic [7:0] evCount;
    logic       irqEn;
    logic       overrun;
    logic       pending;
    logic       irqRaiseReg;
    logic [7:0] rdBuf;
    logic       rdDrive;

    logic       hit;
    logic       capture;
    logic       readHit;
    logic       ctrlWrite;
    logic [7:0] ctrlValue;
    logic [7:0] readMux;

    // The transceiver updates its outputs on the MOUSE_VALID edge, so the
    // packet contents are only stable one edge later.
    assign capture   = validD;
    assign hit       = (bus.BUS_ADDR[7:3] == BASE_ADDR[7:3]);
    assign readHit   = hit && !bus.BUS_WE;
    assign ctrlWrite = hit && bus.BUS_WE && (bus.BUS_ADDR[2:0] == 3'd7);
    assign ctrlValue = {5'b00000, pending, overrun, irqEn};

    // Selected from current register values, so a read on a capture edge
    // returns the pre-capture contents.
    always_comb begin
        readMux = 8'h00;
        case (bus.BUS_ADDR[2:0])
            3'd0:    readMux = statusReg;
            3'd1:    readMux = xReg;
            3'd2:    readMux = yReg;
            3'd3:    readMux = dxReg;
            3'd4:    readMux = dyReg;
            3'd5:    readMux = scrollReg;
            3'd6:    readMux = evCount;
            default: readMux = ctrlValue;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            validD      <= 1'b0;
            statusReg   <= 8'h00;
            xReg        <= 8'h00;
            yReg        <= 8'h00;
            dxReg       <= 8'h00;
            dyReg       <= 8'h00;
            scrollReg   <= 8'h00;
            evCount     <= 8'h00;
            irqEn       <= IRQ_EN_RESET;
            overrun     <= 1'b0;
            pending     <= 1'b0;
            irqRaiseReg <= 1'b0;
            rdBuf       <= 8'h00;
            rdDrive     <= 1'b0;
        end else begin
            validD <= bus.MOUSE_VALID;

            if (capture) begin
                statusReg <= bus.MOUSE_STATUS;
                xReg      <= bus.MOUSE_X;
                yReg      <= bus.MOUSE_Y;
                dxReg     <= bus.MOUSE_DX;
                dyReg     <= bus.MOUSE_DY;
                scrollReg <= bus.MOUSE_SCROLL;
                evCount   <= evCount + 8'd1;
            end

            // A new event beats a coincident acknowledge.
            if (capture) begin
                pending <= 1'b1;
            end else if (bus.IRQ_ACKED) begin
                pending <= 1'b0;
            end

            // An ack in the capture cycle means the previous event was seen,
            // so it is not an overrun. Setting beats a same-cycle clear.
            if (capture && pending && !bus.IRQ_ACKED) begin
                overrun <= 1'b1;
            end else if (ctrlWrite && BUS_DATA[1]) begin
                overrun <= 1'b0;
            end

            if (ctrlWrite) begin
                irqEn <= BUS_DATA[0];
            end

            // Built from the registered PENDING/IRQ_EN, hence one edge behind them.
            irqRaiseReg <= pending & irqEn;

            if (readHit) begin
                rdBuf   <= readMux;
                rdDrive <= 1'b1;
            end else begin
                rdDrive <= 1'b0;
            end
        end
    end

    assign BUS_DATA      = rdDrive ? rdBuf : 8'bzzzz_zzzz;
    assign bus.IRQ_RAISE = irqRaiseReg;

endmodule

// File: tb/tb_mouse_bus_peripheral.sv
// Directed bench for mouse_bus_peripheral. BUS_DATA is a tri1 net, so a
// released bus reads as 8'hFF; no test register value is 8'hFF.
module tb_mouse_bus_peripheral;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       tbDrv = 1'b0;
    logic [7:0] tbDat = 8'h00;
    tri1  [7:0] BUS_DATA;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rdVal;

    mouse_bus_peripheral_if busIf ();

    mouse_bus_peripheral #(
        .BASE_ADDR    (8'hA0),
        .IRQ_EN_RESET (1'b1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (busIf),
        .BUS_DATA (BUS_DATA)
    );

    assign BUS_DATA = tbDrv ? tbDat : 8'bzzzz_zzzz;

    always #5 CLK = ~CLK;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        busIf.BUS_ADDR = a;
        busIf.BUS_WE   = 1'b0;
        cyc(1);
        d = BUS_DATA;
        busIf.BUS_ADDR = 8'h00;
        cyc(1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        busIf.BUS_ADDR = a;
        busIf.BUS_WE   = 1'b1;
        tbDrv          = 1'b1;
        tbDat          = d;
        cyc(1);
        tbDrv          = 1'b0;
        busIf.BUS_WE   = 1'b0;
        busIf.BUS_ADDR = 8'h00;
    endtask

    task automatic setData(input logic [7:0] s, x, y, dx, dy, sc);
        busIf.MOUSE_STATUS = s;
        busIf.MOUSE_X      = x;
        busIf.MOUSE_Y      = y;
        busIf.MOUSE_DX     = dx;
        busIf.MOUSE_DY     = dy;
        busIf.MOUSE_SCROLL = sc;
    endtask

    // Valid sampled at the next edge; capture follows one edge later.
    task automatic pkt();
        busIf.MOUSE_VALID = 1'b1;
        cyc(1);
        busIf.MOUSE_VALID = 1'b0;
    endtask

    task automatic ackPulse();
        busIf.IRQ_ACKED = 1'b1;
        cyc(1);
        busIf.IRQ_ACKED = 1'b0;
    endtask

    initial begin
        busIf.MOUSE_VALID = 1'b0;
        busIf.BUS_ADDR    = 8'h00;
        busIf.BUS_WE      = 1'b0;
        busIf.IRQ_ACKED   = 1'b0;
        setData(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc(2);
        RESET = 1'b0;
        cyc(1);

        // Reset state
        check8("rst_irq", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        check8("rst_bus_z", BUS_DATA, 8'hFF);
        rd(8'hA0, rdVal); check8("rst_status", rdVal, 8'h00);
        rd(8'hA6, rdVal); check8("rst_evcount", rdVal, 8'h00);
        rd(8'hA7, rdVal); check8("rst_ctrl", rdVal, 8'h01);

        // Capture of one packet
        setData(8'h09, 8'd80, 8'd60, 8'h05, 8'hFB, 8'd127);
        pkt();
        cyc(1);
        check8("irq_low_1_after", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        cyc(1);
        check8("irq_high_2_after", {7'b0, busIf.IRQ_RAISE}, 8'h01);
        rd(8'hA0, rdVal); check8("cap_status", rdVal, 8'h09);
        rd(8'hA1, rdVal); check8("cap_x", rdVal, 8'h50);
        rd(8'hA2, rdVal); check8("cap_y", rdVal, 8'h3C);
        rd(8'hA3, rdVal); check8("cap_dx", rdVal, 8'h05);
        rd(8'hA4, rdVal); check8("cap_dy", rdVal, 8'hFB);
        rd(8'hA5, rdVal); check8("cap_scroll", rdVal, 8'h7F);
        rd(8'hA6, rdVal); check8("cap_evcount", rdVal, 8'h01);
        rd(8'hA7, rdVal); check8("cap_ctrl", rdVal, 8'h05);

        // Ack, then two back-to-back packets with no ack -> overrun
        ackPulse();
        cyc(1);
        check8("irq_low_after_ack", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        setData(8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        busIf.MOUSE_VALID = 1'b1;
        cyc(2);
        busIf.MOUSE_VALID = 1'b0;
        cyc(2);
        rd(8'hA7, rdVal); check8("ovr_ctrl", rdVal, 8'h07);
        rd(8'hA6, rdVal); check8("b2b_evcount", rdVal, 8'h03);
        rd(8'hA1, rdVal); check8("b2b_x_latest", rdVal, 8'h11);
        ackPulse();
        cyc(1);
        check8("irq_low_after_ack2", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        wr(8'hA7, 8'h03);
        rd(8'hA7, rdVal); check8("ovr_cleared_ctrl", rdVal, 8'h01);

        // Capture coincident with ack: pending stays, no overrun
        setData(8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56);
        pkt();
        cyc(1);
        busIf.MOUSE_VALID = 1'b1;
        cyc(1);
        busIf.MOUSE_VALID = 1'b0;
        busIf.IRQ_ACKED   = 1'b1;
        cyc(1);
        busIf.IRQ_ACKED   = 1'b0;
        rd(8'hA7, rdVal); check8("cap_ack_ctrl", rdVal, 8'h05);
        rd(8'hA6, rdVal); check8("cap_ack_evcount", rdVal, 8'h05);

        // Overrun set on the same edge as a write-1-to-clear: set wins
        pkt();
        busIf.BUS_ADDR = 8'hA7;
        busIf.BUS_WE   = 1'b1;
        tbDrv          = 1'b1;
        tbDat          = 8'h03;
        cyc(1);
        tbDrv          = 1'b0;
        busIf.BUS_WE   = 1'b0;
        busIf.BUS_ADDR = 8'h00;
        rd(8'hA7, rdVal); check8("ovr_set_wins_ctrl", rdVal, 8'h07);
        ackPulse();
        wr(8'hA7, 8'h03);
        rd(8'hA7, rdVal); check8("ovr_clean_ctrl", rdVal, 8'h01);

        // Masking
        wr(8'hA7, 8'h00);
        pkt();
        cyc(3);
        check8("masked_irq", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        rd(8'hA7, rdVal); check8("masked_ctrl", rdVal, 8'h04);
        wr(8'hA7, 8'h01);
        cyc(1);
        check8("unmask_irq", {7'b0, busIf.IRQ_RAISE}, 8'h01);
        ackPulse();
        cyc(1);

        // Bus discipline
        busIf.BUS_ADDR = 8'h9F;
        cyc(1);
        check8("miss_9f_z", BUS_DATA, 8'hFF);
        busIf.BUS_ADDR = 8'hA8;
        cyc(1);
        check8("miss_a8_z", BUS_DATA, 8'hFF);
        busIf.BUS_ADDR = 8'hA6;
        cyc(1);
        check8("a6_driven", BUS_DATA, 8'h07);
        busIf.BUS_ADDR = 8'h00;
        cyc(1);
        check8("a6_released", BUS_DATA, 8'hFF);
        wr(8'hA1, 8'h99);
        rd(8'hA1, rdVal); check8("x_write_ignored", rdVal, 8'h12);

        // Read on the capture edge returns the pre-capture value
        setData(8'h0B, 8'h13, 8'h24, 8'h35, 8'h46, 8'h57);
        pkt();
        rd(8'hA0, rdVal); check8("read_on_capture_old", rdVal, 8'h01);
        rd(8'hA0, rdVal); check8("read_after_capture_new", rdVal, 8'h0B);

        // EVCOUNT wrap: 8 so far, 248 more make 256
        busIf.MOUSE_VALID = 1'b1;
        cyc(248);
        busIf.MOUSE_VALID = 1'b0;
        cyc(2);
        rd(8'hA6, rdVal); check8("evcount_wrap", rdVal, 8'h00);

        // Async reset mid-read and between MOUSE_VALID and capture
        ackPulse();
        setData(8'h0C, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61);
        pkt();
        cyc(2);
        check8("pre_reset_irq", {7'b0, busIf.IRQ_RAISE}, 8'h01);
        setData(8'h0D, 8'h22, 8'h32, 8'h42, 8'h52, 8'h62);
        busIf.MOUSE_VALID = 1'b1;
        busIf.BUS_ADDR    = 8'hA6;
        cyc(1);
        busIf.MOUSE_VALID = 1'b0;
        check8("pre_reset_drive", BUS_DATA, 8'h01);
        #2;
        RESET = 1'b1;
        #1;
        check8("reset_bus_z_now", BUS_DATA, 8'hFF);
        check8("reset_irq_now", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        busIf.BUS_ADDR = 8'h00;
        cyc(1);
        RESET = 1'b0;
        cyc(2);
        check8("post_reset_irq", {7'b0, busIf.IRQ_RAISE}, 8'h00);
        rd(8'hA0, rdVal); check8("post_reset_status", rdVal, 8'h00);
        rd(8'hA1, rdVal); check8("post_reset_x", rdVal, 8'h00);
        rd(8'hA5, rdVal); check8("post_reset_scroll", rdVal, 8'h00);
        rd(8'hA6, rdVal); check8("post_reset_evcount", rdVal, 8'h00);
        rd(8'hA7, rdVal); check8("post_reset_ctrl", rdVal, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_bus_peripheral.md
# mouse_bus_peripheral

Memory-mapped bus slave that sits directly downstream of the mouse transceiver and presents its outputs to the microprocessor. It snapshots status, position, delta and scroll values after each completed mouse packet. It raises a level interrupt held until the processor acknowledges it, counts packets, and flags overruns.

## Interface

Parameters:
- BASE_ADDR, 8'hA0, base of the 8-byte register window (must be 8-aligned)
- IRQ_EN_RESET, 1'b1, reset value of the interrupt-enable bit

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- MOUSE_VALID  in  1  one-cycle pulse from the transceiver on completion of a packet
- MOUSE_STATUS  in  8  full status byte
- MOUSE_X  in  8  clamped X position
- MOUSE_Y  in  8  clamped Y position
- MOUSE_DX  in  8  signed X delta
- MOUSE_DY  in  8  signed Y delta
- MOUSE_SCROLL  in  8  scroll accumulator
- BUS_ADDR  in  8  processor address
- BUS_DATA  inout  8  shared data bus; driven only during this block's read phase
- BUS_WE  in  1  1 = write cycle, 0 = read
- IRQ_RAISE  out  1  interrupt request level
- IRQ_ACKED  in  1  one-cycle acknowledge from processor

## Operation

- Register map, offset from BASE_ADDR:
  - 0 STATUS
  - 1 X
  - 2 Y
  - 3 DX
  - 4 DY
  - 5 SCROLL
  - 6 EVCOUNT
  - 7 CTRL
- CTRL bits:
  - [0] IRQ_EN (R/W)
  - [1] OVERRUN (read; write 1 clears)
  - [2] PENDING (read-only)
  - [7:3] read as 0
- Offsets 0–6 are read-only; writes to them are ignored.
- Capture timing:
  - The transceiver registers its outputs on the same edge where MOUSE_VALID is high.
  - This block delays MOUSE_VALID by one flop (valid_d) and captures on the edge where valid_d = 1.
  - At that edge, offsets 0–5 load from the inputs together, and EVCOUNT increments mod 256 (255 → 0).
- PENDING control, evaluated per cycle in priority order:
  - capture → PENDING = 1.
  - Otherwise, IRQ_ACKED → PENDING = 0.
  - Capture and IRQ_ACKED in the same cycle → PENDING = 1; the new event wins.
- OVERRUN:
  - Set when a capture occurs while PENDING = 1 and IRQ_ACKED = 0.
  - Cleared by a CTRL write with bit1 = 1.
  - Set and clear in the same cycle → set wins.
  - Captured data is always overwritten; latest packet wins.
- IRQ_RAISE = PENDING & IRQ_EN, registered.
  - Clearing IRQ_EN masks the output but does not clear PENDING.
  - Re-enabling IRQ_EN with PENDING = 1 re-asserts IRQ_RAISE.
- Bus hit: BUS_ADDR[7:3] == BASE_ADDR[7:3]. Any other address: no drive, no write effect.
- Read, BUS_WE = 0 with hit at edge N:
  - The selected byte is registered into the output buffer and the drive enable is set at edge N.
  - BUS_DATA is driven during cycle N+1 and released to Z from edge N+1 onward, unless another read hit occurs.
- A read of CTRL has no side effects; OVERRUN is not clear-on-read.
- Reset values:
  - Data registers: STATUS 0, X 0, Y 0, DX 0, DY 0, SCROLL 0, EVCOUNT 0.
  - CTRL: IRQ_EN = IRQ_EN_RESET, OVERRUN 0, PENDING 0.
  - Other state: valid_d 0, IRQ_RAISE 0, BUS_DATA Z (drive enable 0).
  - Reset is asynchronous: asserting mid-read releases BUS_DATA immediately, and asserting mid-capture discards the capture.

## Timing

- MOUSE_VALID at edge N → registers updated at edge N+1 → IRQ_RAISE high from edge N+2.
- IRQ_ACKED at edge M, with no capture at M → PENDING low at M; IRQ_RAISE low from edge M+1.
- Read latency is one cycle: address at edge N, data valid on BUS_DATA during cycle N+1.
- A write takes effect at the edge where BUS_WE = 1 with a hit; a read in the next cycle returns the new value.
- Back-to-back MOUSE_VALID pulses on consecutive cycles must each produce a capture and an EVCOUNT increment.
  - With no ack in between, the second capture sets OVERRUN.
- A capture on the same edge as a read: the read returns the pre-capture value. Register read is sampled at the edge, before update.

## Test plan

- Capture: reset, then inputs STATUS 8'h09, X 8'd80, Y 8'd60, DX 8'h05, DY 8'hFB, SCROLL 8'd127, with a MOUSE_VALID pulse → reads of 0xA0–0xA5 return 09, 50, 3C, 05, FB, 7F; EVCOUNT 01; IRQ_RAISE high 2 cycles after the pulse.
- Ack and overrun: two packets with no ack → CTRL reads 8'h07. IRQ_ACKED pulse → IRQ_RAISE low next cycle. Write 8'h03 to 0xA7 → CTRL reads 8'h01.
- Simultaneous events:
  - Capture coincident with IRQ_ACKED → PENDING stays 1 and OVERRUN stays 0.
  - Capture-induced overrun in the same cycle as a write-1-to-clear → OVERRUN reads 1.
- Masking: write 8'h00 to CTRL, send a packet → IRQ_RAISE stays 0 and CTRL reads 8'h04. Write 8'h01 → IRQ_RAISE high within 1 cycle.
- Bus discipline and EVCOUNT wrap:
  - Reads at 0x9F and 0xA8 → BUS_DATA stays Z.
  - Read at 0xA6 → driven for exactly one cycle.
  - A write to 0xA1 leaves X unchanged.
  - 256 packets → EVCOUNT reads 00.
- Async reset: assert RESET mid-read and between MOUSE_VALID and capture → BUS_DATA goes Z immediately; IRQ_RAISE 0; all registers at reset values; no capture after release.
